pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Sequences the IF/ID pipeline register and the PC front end of the 5-stage core.
//   Generates pc_running and keep_instr for IF/ID, PC hold/redirect and ID/EX bubble
//   control from ID-stage register addresses, EX-stage load/branch info and memory
//   ready/busy signals. Also owns boot sequencing after start and halt handling.
// PARAMETERS
//   BOOT_CYCLES  2   cycles spent in BOOT after start before fetch runs (0 = skip BOOT)
//   CNT_W        16  width of performance counters
// PORTS
//   clk             in   1      core clock, all state on rising edge
//   rst             in   1      synchronous, active-high reset
//   start           in   1      begin execution (sampled in IDLE/HALTED)
//   halt            in   1      stop execution (ecall/ebreak retire)
//   rs1_raddr       in   5      ID-stage source reg 1
//   rs2_raddr       in   5      ID-stage source reg 2
//   rd_waddr_EX     in   5      EX-stage destination reg
//   mem_read_EX     in   1      EX-stage instruction is a load
//   branch_taken_EX in   1      EX-stage branch/jump resolved taken
//   imem_ready      in   1      instruction memory has valid data this cycle
//   dmem_busy       in   1      data memory multi-cycle access in progress
//   pc_running      out  1      0 forces IF/ID contents to zero
//   keep_instr      out  1      IF/ID holds instr_ID
//   pc_stall        out  1      PC register holds
//   pc_sel          out  1      1 = load PC from branch target
//   flush_EX        out  1      insert bubble into ID/EX
//   stall_all       out  1      freeze every pipeline register
//   state_o         out  3      current FSM state (debug)
//   stall_cycles    out  CNT_W  cycles with keep_instr=1 (PERF_CNT_EN)
//   flush_count     out  CNT_W  taken-branch flushes (PERF_CNT_EN)
// BEHAVIOUR
//   - States: IDLE=0, BOOT=1, RUN=2, FLUSH=3, HALTED=4. State register only; outputs
//     combinational from state and inputs.
//   - Reset: state=IDLE, boot counter=0, counters=0; all outputs 0 while in IDLE.
//   - IDLE: start=1 -> BOOT (counter loaded BOOT_CYCLES-1); BOOT_CYCLES=0 -> RUN directly.
//   - BOOT: pc_running=0, pc_stall=1; counter decrements; at 0 -> RUN.
//   - RUN/FLUSH: pc_running=1. Conditions evaluated in RUN, strict priority:
//     1 halt: -> HALTED; pc_running=0 same cycle.
//     2 dmem_busy: stall_all=1, keep_instr=1, pc_stall=1, flush_EX=0; stay RUN.
//     3 branch_taken_EX: pc_sel=1, flush_EX=1, keep_instr=0, IF/ID loads squashed
//       (pc_running low for this edge is NOT used; flush via flush_EX + FLUSH state);
//       -> FLUSH.
//     4 load-use: mem_read_EX & rd_waddr_EX!=0 & (rd_waddr_EX==rs1_raddr |
//       rd_waddr_EX==rs2_raddr): keep_instr=1, pc_stall=1, flush_EX=1; one cycle only.
//     5 !imem_ready: keep_instr=1, pc_stall=1, flush_EX=1.
//     6 else all control outputs 0.
//   - FLUSH (exactly 1 cycle): flush_EX=1 to squash the wrong-path instruction
//     fetched during the redirect; halt here -> HALTED, dmem_busy holds in FLUSH
//     with stall_all=1; otherwise -> RUN.
//   - x0 never causes a load-use stall. rs compare uses full 5 bits.
//   - HALTED: pc_running=0, pc_stall=1; start=1 -> BOOT; counters hold.
//   - rst mid-operation: next edge returns IDLE regardless of state/inputs.
//   - Simultaneous start & rst: rst wins. Counters saturate at all-ones, never wrap.
// CONFIGURATION
//   PERF_CNT_EN defined: stall_cycles +1 per cycle with keep_instr=1; flush_count +1
//   per entry to FLUSH; both cleared by rst and by start from IDLE/HALTED.
//   Not defined: counter registers absent, stall_cycles/flush_count tied to 0.
// TESTING
//   1 rst=1 2 cycles, start pulse -> BOOT for 2 cycles, pc_running=0, then RUN,
//     pc_running=1 on cycle 3 after start.
//   2 RUN, mem_read_EX=1 rd=5 rs1=5 -> keep_instr=pc_stall=flush_EX=1 for 1 cycle;
//     rd=0 rs1=0 -> no stall.
//   3 branch_taken_EX=1 one cycle -> pc_sel=1,flush_EX=1; next cycle state=FLUSH,
//     flush_EX=1, pc_sel=0; then RUN; flush_count=1.
//   4 branch_taken_EX=1 with dmem_busy=1 -> stall_all=1, pc_sel=0; branch taken once
//     dmem_busy drops.
//   5 imem_ready=0 for 3 cycles in RUN -> keep_instr=1 x3, stall_cycles=3.
//   6 halt=1 in RUN -> HALTED, pc_running=0; rst in FLUSH -> IDLE next edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for the IF/ID register and PC front end.
// Optional performance counters are enabled with `define PERF_CNT_EN.
//
// Ports:
//   clk, rst           - core clock, synchronous active-high reset
//   start, halt        - begin execution (IDLE/HALTED) / stop execution
//   rs1_raddr,
//   rs2_raddr          - ID-stage source register addresses
//   rd_waddr_EX,
//   mem_read_EX        - EX-stage destination register and load flag
//   branch_taken_EX    - EX-stage branch/jump resolved taken
//   imem_ready         - instruction memory data valid this cycle
//   dmem_busy          - data memory multi-cycle access in progress
//   pc_running         - 0 forces IF/ID contents to zero
//   keep_instr         - IF/ID holds its instruction
//   pc_stall, pc_sel   - PC hold / load PC from branch target
//   flush_EX           - bubble into ID/EX
//   stall_all          - freeze every pipeline register
//   state_o            - current FSM state (debug)
//   stall_cycles,
//   flush_count        - saturating perf counters (0 when PERF_CNT_EN undefined)
module pipe_hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic [4:0]       rs1_raddr,
    input  logic [4:0]       rs2_raddr,
    input  logic [4:0]       rd_waddr_EX,
    input  logic             mem_read_EX,
    input  logic             branch_taken_EX,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             pc_running,
    output logic             keep_instr,
    output logic             pc_stall,
    output logic             pc_sel,
    output logic             flush_EX,
    output logic             stall_all,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BOOT   = 3'd1,
        RUN    = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } state_e;

    localparam int unsigned BW = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_INIT =
        (BOOT_CYCLES > 0) ? BW'(BOOT_CYCLES - 1) : '0;

    state_e          state_q, state_d;
    logic   [BW-1:0] cnt_q, cnt_d;
    logic            load_use;
    logic            start_clr;
    logic            flush_enter;

    // x0 is never written, so it can never be a real dependency.
    assign load_use = mem_read_EX && (rd_waddr_EX != 5'd0) &&
                      ((rd_waddr_EX == rs1_raddr) ||
                       (rd_waddr_EX == rs2_raddr));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_running  = 1'b0;
        keep_instr  = 1'b0;
        pc_stall    = 1'b0;
        pc_sel      = 1'b0;
        flush_EX    = 1'b0;
        stall_all   = 1'b0;
        start_clr   = 1'b0;
        flush_enter = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (state_q == HALTED) begin
                    pc_stall = 1'b1;
                end
                if (start) begin
                    start_clr = 1'b1;
                    cnt_d     = BOOT_INIT;
                    state_d   = (BOOT_CYCLES == 0) ? RUN : BOOT;
                end
            end
            BOOT: begin
                pc_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                pc_running = 1'b1;
                if (halt) begin
                    pc_running = 1'b0;
                    state_d    = HALTED;
                end else if (dmem_busy) begin
                    // Whole pipe frozen; a pending branch waits for this.
                    stall_all  = 1'b1;
                    keep_instr = 1'b1;
                    pc_stall   = 1'b1;
                end else if (branch_taken_EX) begin
                    pc_sel      = 1'b1;
                    flush_EX    = 1'b1;
                    flush_enter = 1'b1;
                    state_d     = FLUSH;
                end else if (load_use || !imem_ready) begin
                    keep_instr = 1'b1;
                    pc_stall   = 1'b1;
                    flush_EX   = 1'b1;
                end
            end
            FLUSH: begin
                pc_running = 1'b1;
                if (halt) begin
                    pc_running = 1'b0;
                    state_d    = HALTED;
                end else if (dmem_busy) begin
                    stall_all  = 1'b1;
                    keep_instr = 1'b1;
                    pc_stall   = 1'b1;
                end else begin
                    // Squash the wrong-path fetch made during the redirect.
                    flush_EX = 1'b1;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_o = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (start_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (keep_instr && (stall_q != '1)) begin
                stall_d = stall_q + 1'b1;
            end
            if (flush_enter && (flush_q != '1)) begin
                flush_d = flush_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    logic unused_perf;
    assign unused_perf  = start_clr ^ flush_enter;
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario testbench for pipe_hazard_ctrl.
// Expected control vectors are queued as stimulus is applied.
module tb_pipe_hazard_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_BOOT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FL   = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       halt;
        logic       mr;
        logic       br;
        logic       ir;
        logic       db;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst, start, halt;
    logic [4:0]  rs1_raddr, rs2_raddr, rd_waddr_EX;
    logic        mem_read_EX, branch_taken_EX, imem_ready, dmem_busy;
    logic        pc_running, keep_instr, pc_stall, pc_sel;
    logic        flush_EX, stall_all;
    logic [2:0]  state_o;
    logic [15:0] stall_cycles, flush_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  sb[$];

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .halt            (halt),
        .rs1_raddr       (rs1_raddr),
        .rs2_raddr       (rs2_raddr),
        .rd_waddr_EX     (rd_waddr_EX),
        .mem_read_EX     (mem_read_EX),
        .branch_taken_EX (branch_taken_EX),
        .imem_ready      (imem_ready),
        .dmem_busy       (dmem_busy),
        .pc_running      (pc_running),
        .keep_instr      (keep_instr),
        .pc_stall        (pc_stall),
        .pc_sel          (pc_sel),
        .flush_EX        (flush_EX),
        .stall_all       (stall_all),
        .state_o         (state_o),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(bit r, bit st, bit h, bit mr, bit br,
                                 bit ir, bit db, logic [4:0] s1,
                                 logic [4:0] s2, logic [4:0] d);
        stim_t s;
        s = '{r, st, h, mr, br, ir, db, s1, s2, d};
        return s;
    endfunction

    function automatic logic [8:0] ex(bit pr, bit ki, bit ps, bit sel,
                                      bit fl, bit sa, logic [2:0] st);
        return {pr, ki, ps, sel, fl, sa, st};
    endfunction

    function automatic logic [8:0] obs();
        return {pc_running, keep_instr, pc_stall, pc_sel,
                flush_EX, stall_all, state_o};
    endfunction

    task automatic drive(input stim_t s);
        rst             = s.rst;
        start           = s.start;
        halt            = s.halt;
        mem_read_EX     = s.mr;
        branch_taken_EX = s.br;
        imem_ready      = s.ir;
        dmem_busy       = s.db;
        rs1_raddr       = s.rs1;
        rs2_raddr       = s.rs2;
        rd_waddr_EX     = s.rd;
    endtask

    task automatic test_reset();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs() !== ex(0, 0, 0, 0, 0, 0, S_IDLE) || stall_cycles !== 16'd0
            || flush_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset: got %b/%0d/%0d want %b/0/0", obs(),
                     stall_cycles, flush_count, ex(0, 0, 0, 0, 0, 0, S_IDLE));
        end
        s.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 0, 0, 0, 0, S_IDLE));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 0, 0, 0, 0, S_IDLE));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL rst_vs_start step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
    endtask

    task automatic test_boot();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        s.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 0, 0, 0, 0, S_IDLE));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 1, 0, 0, 0, S_BOOT));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 1, 0, 0, 0, S_BOOT));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL boot step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        s.push_back(mk(0, 0, 0, 1, 0, 1, 0, 5, 0, 5));
        e.push_back(ex(1, 1, 1, 0, 1, 0, S_RUN));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5, 0, 5));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        s.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 7, 7));
        e.push_back(ex(1, 1, 1, 0, 1, 0, S_RUN));
        s.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        s.push_back(mk(0, 0, 0, 1, 0, 1, 0, 21, 0, 5));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL load_use step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
    endtask

    task automatic test_branch();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        logic [15:0] fc;
        s.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 1, 1, 0, S_RUN));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 1, 0, S_FL));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL branch step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
        fc = PERF ? 16'd1 : 16'd0;
        n_cmp++;
        if (flush_count !== fc) begin
            n_err++;
            $display("FAIL branch flush_count: got %0d want %0d",
                     flush_count, fc);
        end
    endtask

    task automatic test_branch_dmem();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        logic [15:0] fc;
        s.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        e.push_back(ex(1, 1, 1, 0, 0, 1, S_RUN));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        e.push_back(ex(1, 1, 1, 0, 0, 1, S_RUN));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 1, 1, 0, S_RUN));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        e.push_back(ex(1, 1, 1, 0, 0, 1, S_FL));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 1, 0, S_FL));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL branch_dmem step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
        fc = PERF ? 16'd2 : 16'd0;
        n_cmp++;
        if (flush_count !== fc) begin
            n_err++;
            $display("FAIL branch_dmem flush_count: got %0d want %0d",
                     flush_count, fc);
        end
    endtask

    task automatic test_halt();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        logic [15:0] sc, fc;
        s.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 0, 0, 0, 0, S_RUN));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 1, 0, 0, 0, S_HALT));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 1, 0, 0, 0, S_HALT));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL halt step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
        sc = PERF ? 16'd5 : 16'd0;
        fc = PERF ? 16'd2 : 16'd0;
        n_cmp++;
        if (stall_cycles !== sc || flush_count !== fc) begin
            n_err++;
            $display("FAIL halt counters: got %0d/%0d want %0d/%0d",
                     stall_cycles, flush_count, sc, fc);
        end
        s.delete();
        e.delete();
        s.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 1, 0, 0, 0, S_HALT));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 1, 0, 0, 0, S_BOOT));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 1, 0, 0, 0, S_BOOT));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL restart step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
        n_cmp++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_err++;
            $display("FAIL restart counters: got %0d/%0d want 0/0",
                     stall_cycles, flush_count);
        end
    endtask

    task automatic test_imem();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        logic [15:0] sc;
        repeat (3) begin
            s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            e.push_back(ex(1, 1, 1, 0, 1, 0, S_RUN));
        end
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 0, 0, 0, S_RUN));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL imem step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
        sc = PERF ? 16'd3 : 16'd0;
        n_cmp++;
        if (stall_cycles !== sc) begin
            n_err++;
            $display("FAIL imem stall_cycles: got %0d want %0d",
                     stall_cycles, sc);
        end
    endtask

    task automatic test_rst_flush();
        stim_t      s[$];
        logic [8:0] e[$];
        logic [8:0] want;
        s.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        e.push_back(ex(1, 0, 0, 1, 1, 0, S_RUN));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        e.push_back(ex(1, 1, 1, 0, 0, 1, S_FL));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        e.push_back(ex(0, 0, 0, 0, 0, 0, S_IDLE));
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i]);
            sb.push_back(e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL rst_flush step %0d: got %b want %b",
                         i, obs(), want);
            end
        end
        n_cmp++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_err++;
            $display("FAIL rst_flush counters: got %0d/%0d want 0/0",
                     stall_cycles, flush_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_boot();
        test_load_use();
        test_branch();
        test_branch_dmem();
        test_halt();
        test_imem();
        test_rst_flush();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
